// File: rtl/bf_pkg.sv
// Shared types and constants for the bellmanford drain path.
// Distance encoding, address widths and the streamer state enum.
package bf_pkg;

  localparam int NODE_ADDR_W = 13;
  localparam int DIST_W      = 16;

  localparam logic [DIST_W-1:0] INF_DIST = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_NEG,
    S_DONE
  } streamer_state_t;

endpackage

// File: rtl/result_streamer_if.sv
// Valid/ready stream carrying distance words out of result_streamer.
// master drives data and flags, slave drives OutReady.
interface result_streamer_if #(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] OutData;
  logic              OutValid;
  logic              OutReady;
  logic              OutUnreach;
  logic              OutLast;

  modport master (
    output OutData,
    output OutValid,
    output OutUnreach,
    output OutLast,
    input  OutReady
  );

  modport slave (
    input  OutData,
    input  OutValid,
    input  OutUnreach,
    input  OutLast,
    output OutReady
  );

endinterface

// File: rtl/result_streamer_stats.sv
// Reach counter and running max over streamed distance words.
// Only instantiated when RESULT_STREAMER_STATS_EN is defined.
module stream_stats
  import bf_pkg::*;
#(
  parameter int ADDR_W = NODE_ADDR_W,
  parameter int DATA_W = DIST_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  output logic [ADDR_W:0]   reach_count,
  output logic [DATA_W-1:0] max_dist
);

  localparam logic [DATA_W-1:0] INF = DATA_W'(INF_DIST);

  logic reach;
  assign reach = (word != INF);

  // count reachable words and track the largest one as they load
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      reach_count <= '0;
      max_dist    <= '0;
    end else if (load && reach) begin
      reach_count <= reach_count + 1'b1;
      if (word > max_dist)
        max_dist <= word;
    end
  end

endmodule

// File: rtl/result_streamer.sv
// Drains bellmanford Output Memory onto a valid/ready stream.
// Optional stats (ReachCount/MaxDist) under RESULT_STREAMER_STATS_EN.
module result_streamer
  import bf_pkg::*;
#(
  parameter int NUM_NODES = 8192,
  parameter int ADDR_W    = NODE_ADDR_W,
  parameter int DATA_W    = DIST_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Finish,
  input  logic              NegCycle,
  output logic [ADDR_W-1:0] OMAR,
  input  logic [DATA_W-1:0] OMDR,
  result_streamer_if.master strm,
  output logic              NegFlag,
  output logic              Done,
  output logic [ADDR_W:0]   ReachCount,
  output logic [DATA_W-1:0] MaxDist
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_NODES - 1);
  localparam logic [DATA_W-1:0] INF  = DATA_W'(INF_DIST);

  streamer_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic load, clr, hs;

  assign hs      = strm.OutValid && strm.OutReady;
  assign OMAR    = addr_q;
  assign NegFlag = (state_q == S_NEG);
  assign Done    = (state_q == S_NEG) || (state_q == S_DONE);

  // next state plus load/clear strobes for the datapath
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (NegCycle)
          state_d = S_NEG;
        else if (Finish) begin
          state_d = S_STREAM;
          clr     = 1'b1;
        end
      end
      S_STREAM: begin
        if (NegCycle) begin
          if (!strm.OutValid || strm.OutReady)
            state_d = S_NEG;
        end else begin
          load = !strm.OutValid ||
                 (strm.OutReady && !strm.OutLast);
          if (hs && strm.OutLast)
            state_d = S_DONE;
        end
      end
      S_NEG: begin
        if (!NegCycle && !Finish)
          state_d = S_IDLE;
      end
      S_DONE: begin
        if (!Finish)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // address counter and output register; counter parks on the last index
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q          <= '0;
      strm.OutData    <= '0;
      strm.OutValid   <= 1'b0;
      strm.OutUnreach <= 1'b0;
      strm.OutLast    <= 1'b0;
    end else begin
      if (clr)
        addr_q <= '0;
      else if (load && addr_q != LAST)
        addr_q <= addr_q + 1'b1;
      if (load) begin
        strm.OutData    <= OMDR;
        strm.OutValid   <= 1'b1;
        strm.OutUnreach <= (OMDR == INF);
        strm.OutLast    <= (addr_q == LAST);
      end else if (hs) begin
        strm.OutValid <= 1'b0;
      end
    end
  end

`ifdef RESULT_STREAMER_STATS_EN
  stream_stats #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_stats (
    .clock       (clock),
    .reset       (reset),
    .clr         (clr),
    .load        (load),
    .word        (OMDR),
    .reach_count (ReachCount),
    .max_dist    (MaxDist)
  );
`else
  assign ReachCount = '0;
  assign MaxDist    = '0;
`endif

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer with a 4-word Output Memory.
// Expected values are hand-computed per vector.
module tb_result_streamer;

  logic        clock = 1'b0;
  logic        reset;
  logic        Finish;
  logic        NegCycle;
  logic [12:0] OMAR;
  logic [15:0] OMDR;
  logic        NegFlag;
  logic        Done;
  logic [13:0] ReachCount;
  logic [15:0] MaxDist;

  logic [15:0] mem [4];

  int vectors = 0;
  int miscompares = 0;

  result_streamer_if #(.DATA_W(16)) sif ();

  result_streamer #(
    .NUM_NODES (4),
    .ADDR_W    (13),
    .DATA_W    (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .Finish     (Finish),
    .NegCycle   (NegCycle),
    .OMAR       (OMAR),
    .OMDR       (OMDR),
    .strm       (sif.master),
    .NegFlag    (NegFlag),
    .Done       (Done),
    .ReachCount (ReachCount),
    .MaxDist    (MaxDist)
  );

  always #5 clock = ~clock;

  always_comb begin
    OMDR = '0;
    if (OMAR < 13'd4)
      OMDR = mem[OMAR[1:0]];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int exp_rc1, exp_md1, exp_rc4;
  int idx;
  bit stalled;
  logic [15:0] held;
  bit pat [4];

  initial begin
`ifdef RESULT_STREAMER_STATS_EN
    exp_rc1 = 3; exp_md1 = 5; exp_rc4 = 2;
`else
    exp_rc1 = 0; exp_md1 = 0; exp_rc4 = 0;
`endif
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    mem[0] = 16'h0000; mem[1] = 16'h0005;
    mem[2] = 16'hFFFF; mem[3] = 16'h0003;
    reset = 1; Finish = 0; NegCycle = 0;
    sif.OutReady = 0;
    tick(); tick();
    reset = 0;

    chk("rst_valid", sif.OutValid, 0);
    chk("rst_data", sif.OutData, 0);
    chk("rst_omar", OMAR, 0);
    chk("rst_done", Done, 0);
    chk("rst_neg", NegFlag, 0);
    chk("rst_rc", ReachCount, 0);
    chk("rst_md", MaxDist, 0);

    // 1: full-speed stream
    Finish = 1; sif.OutReady = 1;
    tick();
    chk("t1_lat", sif.OutValid, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", sif.OutValid, 1);
      chk("t1_data", sif.OutData, mem[i]);
      chk("t1_unr", sif.OutUnreach, (i == 2) ? 1 : 0);
      chk("t1_last", sif.OutLast, (i == 3) ? 1 : 0);
      chk("t1_done", Done, 0);
      tick();
    end
    chk("t1_done_end", Done, 1);
    chk("t1_valid_end", sif.OutValid, 0);
    chk("t1_rc", ReachCount, exp_rc1);
    chk("t1_md", MaxDist, exp_md1);
    Finish = 0;
    tick();
    chk("t1_idle", Done, 0);
    chk("t1_hold_rc", ReachCount, exp_rc1);

    // 2: ready pattern 1,0,0,1 with stall stability
    Finish = 1; idx = 0; stalled = 0; held = '0;
    for (int c = 0; c < 40 && !Done; c++) begin
      sif.OutReady = pat[c % 4];
      if (sif.OutValid) begin
        if (stalled)
          chk("t2_stall", sif.OutData, held);
        if (sif.OutReady) begin
          chk("t2_data", sif.OutData, (idx < 4) ? mem[idx] : 16'hDEAD);
          chk("t2_last", sif.OutLast, (idx == 3) ? 1 : 0);
          idx++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = sif.OutData;
        end
      end
      tick();
    end
    chk("t2_count", idx, 4);
    chk("t2_done", Done, 1);
    chk("t2_rc", ReachCount, exp_rc1);
    Finish = 0;
    tick();

    // 3: NegCycle and Finish together
    sif.OutReady = 1; NegCycle = 1; Finish = 1;
    tick();
    chk("t3_neg", NegFlag, 1);
    chk("t3_done", Done, 1);
    chk("t3_valid", sif.OutValid, 0);
    tick();
    chk("t3_valid2", sif.OutValid, 0);
    NegCycle = 0; Finish = 0;
    tick();
    chk("t3_idle", NegFlag, 0);

    // 4: NegCycle after two words
    Finish = 1;
    tick(); tick();
    chk("t4_w0", sif.OutData, 16'h0000);
    tick();
    chk("t4_w1", sif.OutData, 16'h0005);
    NegCycle = 1;
    tick();
    chk("t4_neg", NegFlag, 1);
    chk("t4_valid", sif.OutValid, 0);
    chk("t4_rc", ReachCount, exp_rc4);
    chk("t4_md", MaxDist, exp_md1);
    NegCycle = 0; Finish = 0;
    tick();

    // 5: reset mid-stream then restart
    Finish = 1;
    tick(); tick(); tick(); tick();
    chk("t5_w2", sif.OutData, 16'hFFFF);
    chk("t5_unr", sif.OutUnreach, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("t5_valid", sif.OutValid, 0);
    chk("t5_data", sif.OutData, 0);
    chk("t5_unr0", sif.OutUnreach, 0);
    chk("t5_omar", OMAR, 0);
    chk("t5_rc", ReachCount, 0);
    tick(); tick();
    chk("t5_r0", sif.OutData, 16'h0000);
    chk("t5_omar1", OMAR, 1);
    tick();
    chk("t5_r1", sif.OutData, 16'h0005);
    tick(); tick(); tick();
    chk("t5_done", Done, 1);
    Finish = 0;
    tick();

    // 6: all unreachable
    for (int i = 0; i < 4; i++) mem[i] = 16'hFFFF;
    Finish = 1;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      chk("t6_unr", sif.OutUnreach, 1);
      tick();
    end
    chk("t6_done", Done, 1);
    chk("t6_rc", ReachCount, 0);
    chk("t6_md", MaxDist, 0);
    Finish = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
